// File: rtl/muldiv_sequencer.sv
// Sequencer for the mult/div resource: 32-step shift-add multiply or restoring divide into HI/LO.
// MULDIV_UNSIGNED_EN enables multu/divu through Op[1].
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;

  logic               uns;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               b_zero;

`ifdef MULDIV_UNSIGNED_EN
  assign uns = Op[1];
`else
  // Op[1] has no meaning here: every op is signed.
  assign uns = Op[1] & 1'b0;
`endif

  assign sa     = A[WIDTH-1] & ~uns;
  assign sb     = B[WIDTH-1] & ~uns;
  assign mag_a  = sa ? (~A + 1'b1) : A;
  assign mag_b  = sb ? (~B + 1'b1) : B;
  assign b_zero = (B == '0);

  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     d_t;
  logic [WIDTH:0]     d_diff;
  logic               d_ge;

  assign m_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
  assign d_t    = {p_hi, p_lo[WIDTH-1]};
  assign d_diff = d_t - {1'b0, opnd};
  assign d_ge   = (d_t >= {1'b0, opnd});

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod     = {p_hi, p_lo};
  assign prod_fix = neg_res ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_res ? (~p_lo + 1'b1) : p_lo;
  assign rem_fix  = neg_rem ? (~p_hi + 1'b1) : p_hi;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      opnd    <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Busy    <= (state == CALC);
      unique case (state)
        IDLE: begin
          if (Start) begin
            cnt     <= '0;
            is_div  <= Op[0];
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            dz      <= Op[0] & b_zero;
            p_hi    <= '0;
            if (Op[0]) begin
              opnd <= mag_b;
              p_lo <= mag_a;
            end else begin
              opnd <= mag_a;
              p_lo <= mag_b;
            end
            // Divide by zero skips the iterations but keeps
            // the one-cycle hop through SIGN before Done.
            state <= (Op[0] & b_zero) ? SIGN : CALC;
          end
        end
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            state <= SIGN;
          end else begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              p_hi <= d_ge ? d_diff[WIDTH-1:0]
                           : d_t[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], d_ge};
            end else begin
              p_hi <= m_sum[WIDTH:1];
              p_lo <= {m_sum[0], p_lo[WIDTH-1:1]};
            end
          end
        end
        SIGN: begin
          state   <= DONE;
          Done    <= 1'b1;
          DivZero <= dz;
          if (!dz) begin
            if (is_div) begin
              HI <= rem_fix;
              LO <= quo_fix;
            end else begin
              HI <= prod_fix[2*WIDTH-1:WIDTH];
              LO <= prod_fix[WIDTH-1:0];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table,
// multi-cycle corner sequences, randomized ops vs. an arithmetic model.
module tb_muldiv_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HI;
  logic [31:0] LO;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .A(A), .B(B), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operands.
  task automatic model(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic dz);
    logic   uns;
    longint sa, sb, p, q, r;
    logic [63:0] up;
`ifdef MULDIV_UNSIGNED_EN
    uns = op[1];
`else
    uns = 1'b0;
`endif
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    if (!op[0]) begin
      if (uns) begin
        up = 64'(a) * 64'(b);
        {m_hi, m_lo} = up;
      end else begin
        p = sa * sb;
        {m_hi, m_lo} = p;
      end
    end else if (b == 0) begin
      dz = 1'b1;
    end else if (uns) begin
      m_lo = a / b;
      m_hi = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
    end
  endtask

  task automatic start_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(negedge Clk);
    Start = 1'b0;
    Op = 2'($urandom);
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (1) begin
      if (Busy) bcnt++;
      if (Done || lat >= 100) break;
      @(negedge Clk);
      lat++;
    end
    check("done_seen", 64'(Done), 64'd1);
  endtask

  task automatic run_vec(input string tag,
                         input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] ehi,
                         input logic [31:0] elo,
                         input logic edz);
    int lat, bcnt;
    start_op(op, a, b);
    wait_done(lat, bcnt);
    check({tag, "_hi"}, 64'(HI), 64'(ehi));
    check({tag, "_lo"}, 64'(LO), 64'(elo));
    check({tag, "_dz"}, 64'(DivZero), 64'(edz));
    check({tag, "_lat"}, 64'(lat), edz ? 64'd1 : 64'd34);
    check({tag, "_busy"}, 64'(bcnt), edz ? 64'd0 : 64'd33);
    @(negedge Clk);
    check({tag, "_pulse"}, 64'({Done, DivZero}), 64'd0);
  endtask

  initial begin
    logic dz;
    int lat, bcnt;
    logic [1:0] op;
    logic [31:0] a, b;

    vecs[0] = '{2'b00, 32'd7, 32'hFFFFFFFD,
                32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2] = '{2'b01, 32'h56781234, 32'h00010000,
                32'h00001234, 32'h00005678, 1'b0};
    vecs[3] = '{2'b01, 32'd5, 32'd0,
                32'h00001234, 32'h00005678, 1'b1};
    vecs[4] = '{2'b01, 32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000, 1'b0};
`ifdef MULDIV_UNSIGNED_EN
    vecs[5] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 1'b0};
`else
    vecs[5] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h00000000, 32'h00000001, 1'b0};
`endif
    vecs[6] = '{2'b00, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h00000000, 1'b0};
    vecs[7] = '{2'b01, 32'd7, 32'hFFFFFFFE,
                32'h00000001, 32'hFFFFFFFD, 1'b0};

    Reset = 1'b1;
    Start = 1'b0;
    Op = '0;
    A = '0;
    B = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_dz", 64'(DivZero), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b, dz);
      run_vec($sformatf("vec%0d", i), vecs[i].op,
              vecs[i].a, vecs[i].b,
              vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // Start pulsed mid-operation must be ignored.
    start_op(2'b00, 32'd3, 32'd4);
    repeat (5) @(negedge Clk);
    Start = 1'b1;
    Op = 2'b01;
    A = 32'd9;
    B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(lat, bcnt);
    check("ign_hi", 64'(HI), 64'd0);
    check("ign_lo", 64'(LO), 64'd12);
    repeat (3) @(negedge Clk);
    check("ign_idle", 64'({Busy, Done}), 64'd0);

    // Reset in the middle of a multiply.
    start_op(2'b00, 32'd100, 32'd200);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    repeat (2) @(negedge Clk);
    check("abort_stay", 64'({Busy, Done}), 64'd0);
    m_hi = '0;
    m_lo = '0;
    run_vec("after_rst", 2'b00, 32'd6, 32'd7,
            32'd0, 32'd42, 1'b0);
    model(2'b00, 32'd6, 32'd7, dz);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      model(op, a, b, dz);
      run_vec($sformatf("rnd%0d", i), op, a, b,
              m_hi, m_lo, dz);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
